// File: rtl/usr_ctrl.sv
// Command sequencer for a universal shift register: accepts load/shift/rotate
// commands, drives the register's mode and serial inputs, and captures its output.
module usr_ctrl #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [CNT_W-1:0] cmd_cnt,
  input  logic             ser_in,
  input  logic [WIDTH-1:0] usr_dout,
  output logic [1:0]       usr_s,
  output logic [WIDTH-1:0] usr_din,
  output logic             usr_ldin,
  output logic             usr_rdin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_SHR  = 2'b01;
  localparam logic [1:0] OP_SHL  = 2'b10;
  localparam logic [1:0] OP_ROR  = 2'b11;

  localparam logic [1:0] M_LOAD  = 2'b00;
  localparam logic [1:0] M_HOLD  = 2'b01;
  localparam logic [1:0] M_RIGHT = 2'b10;
  localparam logic [1:0] M_LEFT  = 2'b11;

  state_t             state, state_d;
  logic [1:0]         op_q, op_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   result_q, result_d;

  // State and command registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      op_q     <= '0;
      data_q   <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state    <= state_d;
      op_q     <= op_d;
      data_q   <= data_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  // Next-state and Moore output decode
  always_comb begin
    state_d   = state;
    op_d      = op_q;
    data_d    = data_q;
    cnt_d     = cnt_q;
    result_d  = result_q;
    cmd_ready = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    usr_s     = M_HOLD;
    usr_din   = '0;
    usr_ldin  = 1'b0;
    usr_rdin  = 1'b0;

    case (state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
        if (cmd_valid) begin
          op_d   = cmd_op;
          data_d = cmd_data;
          cnt_d  = cmd_cnt;
          if (cmd_op == OP_LOAD)
            state_d = S_LOAD;
          else if (cmd_cnt == '0)
            state_d = S_DONE;
          else
            state_d = S_SHIFT;
        end
      end
      S_LOAD: begin
        usr_s   = M_LOAD;
        usr_din = data_q;
        state_d = S_DONE;
      end
      S_SHIFT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1))
          state_d = S_DONE;
        // Rotate feeds the register's own LSB back into the MSB end
        case (op_q)
          OP_SHR: begin
            usr_s    = M_RIGHT;
            usr_rdin = ser_in;
          end
          OP_ROR: begin
            usr_s    = M_RIGHT;
            usr_rdin = usr_dout[0];
          end
          OP_SHL: begin
            usr_s    = M_LEFT;
            usr_ldin = ser_in;
          end
          default: usr_s = M_HOLD;
        endcase
      end
      S_DONE: begin
        done     = 1'b1;
        result_d = usr_dout;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign result = result_q;

endmodule

// File: tb/tb_usr_ctrl.sv
// Directed bench for usr_ctrl with a behavioural universal shift register
// closing the usr_s/usr_din/serial loop back into usr_dout.
module tb_usr_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [3:0] cmd_data;
  logic [2:0] cmd_cnt;
  logic       ser_in;
  logic [3:0] usr_dout;
  logic [1:0] usr_s;
  logic [3:0] usr_din;
  logic       usr_ldin;
  logic       usr_rdin;
  logic       busy;
  logic       done;
  logic [3:0] result;

  int checks   = 0;
  int failures = 0;

  usr_ctrl #(.WIDTH(4), .CNT_W(3)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .cmd_cnt(cmd_cnt), .ser_in(ser_in),
    .usr_dout(usr_dout), .usr_s(usr_s), .usr_din(usr_din), .usr_ldin(usr_ldin),
    .usr_rdin(usr_rdin), .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  // Shift register model: right shift enters at MSB, left shift enters at LSB
  logic [3:0] model_q;
  assign usr_dout = model_q;
  always_ff @(posedge clk) begin
    case (usr_s)
      2'b00:   model_q <= usr_din;
      2'b10:   model_q <= {usr_rdin, model_q[3:1]};
      2'b11:   model_q <= {model_q[2:0], usr_ldin};
      default: model_q <= model_q;
    endcase
  end

  typedef struct {
    logic [1:0] op;
    logic [3:0] data;
    logic [2:0] cnt;
    logic       ser;
    logic [1:0] mode;
    int         lat;
    logic [3:0] res;
  } vec_t;

  vec_t vecs[12];

  function automatic vec_t mk(logic [1:0] op, logic [3:0] data, logic [2:0] cnt,
                              logic ser, logic [1:0] mode, int lat, logic [3:0] res);
    vec_t v;
    v.op = op; v.data = data; v.cnt = cnt; v.ser = ser;
    v.mode = mode; v.lat = lat; v.res = res;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (cmd_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("wait_idle", 32'(cmd_ready), 32'd1);
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int bad = 0;
    int done_at = 0;
    logic [1:0] es;
    logic [3:0] edin;
    logic       erdin, eldin;
    wait_idle();
    @(negedge clk);
    cmd_op = v.op; cmd_data = v.data; cmd_cnt = v.cnt; ser_in = v.ser;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_op   = 2'($urandom);
    cmd_data = 4'($urandom);
    cmd_cnt  = 3'($urandom);
    for (int i = 1; i <= v.lat; i++) begin
      @(negedge clk);
      es    = (i < v.lat) ? v.mode : 2'b01;
      edin  = (es == 2'b00) ? v.data : 4'b0000;
      erdin = (es == 2'b10) ? ((v.op == 2'b01) ? ser_in : model_q[0]) : 1'b0;
      eldin = (es == 2'b11) ? ser_in : 1'b0;
      if (usr_s !== es) bad++;
      if (usr_din !== edin) bad++;
      if (usr_rdin !== erdin) bad++;
      if (usr_ldin !== eldin) bad++;
      if (busy !== 1'b1) bad++;
      if (cmd_ready !== 1'b0) bad++;
      if (done === 1'b1 && done_at == 0) done_at = i;
    end
    check($sformatf("v%0d_seq", idx), 32'(bad), 32'd0);
    check($sformatf("v%0d_done_at", idx), 32'(done_at), 32'(v.lat));
    @(negedge clk);
    check($sformatf("v%0d_result", idx), 32'(result), 32'(v.res));
    check($sformatf("v%0d_idle", idx), {29'd0, busy, done, cmd_ready}, 32'd1);
  endtask

  initial begin
    int bad;
    int done_at;
    int ready_at;
    logic [1:0] first_s;

    vecs[0]  = mk(2'b00, 4'b1010, 3'd0, 1'b0, 2'b00, 2, 4'b1010);
    vecs[1]  = mk(2'b01, 4'b1111, 3'd0, 1'b1, 2'b01, 1, 4'b1010);
    vecs[2]  = mk(2'b00, 4'b0001, 3'd0, 1'b0, 2'b00, 2, 4'b0001);
    vecs[3]  = mk(2'b10, 4'b0000, 3'd3, 1'b1, 2'b11, 4, 4'b1111);
    vecs[4]  = mk(2'b00, 4'b1000, 3'd0, 1'b0, 2'b00, 2, 4'b1000);
    vecs[5]  = mk(2'b11, 4'b0000, 3'd5, 1'b0, 2'b10, 6, 4'b0100);
    vecs[6]  = mk(2'b01, 4'b0000, 3'd2, 1'b0, 2'b10, 3, 4'b0001);
    vecs[7]  = mk(2'b01, 4'b0000, 3'd1, 1'b1, 2'b10, 2, 4'b1000);
    vecs[8]  = mk(2'b10, 4'b0000, 3'd7, 1'b0, 2'b11, 8, 4'b0000);
    vecs[9]  = mk(2'b00, 4'b0110, 3'd0, 1'b0, 2'b00, 2, 4'b0110);
    vecs[10] = mk(2'b11, 4'b0000, 3'd0, 1'b1, 2'b01, 1, 4'b0110);
    vecs[11] = mk(2'b11, 4'b0000, 3'd7, 1'b0, 2'b10, 8, 4'b1100);

    rst = 1'b0; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_data = 4'h0;
    cmd_cnt = 3'd0; ser_in = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_usr_s", 32'(usr_s), 32'd1);
    check("rst_outs", {26'd0, busy, done, usr_ldin, usr_rdin, 2'b00}, 32'd0);
    check("rst_din", 32'(usr_din), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check("rst_ready", 32'(cmd_ready), 32'd1);

    for (int i = 0; i < 12; i++) run_vec(i, vecs[i]);

    // Back-to-back: valid stays high, second command must wait for IDLE
    wait_idle();
    @(negedge clk);
    cmd_op = 2'b00; cmd_data = 4'b0011; cmd_cnt = 3'd0; cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    cmd_op = 2'b10; cmd_data = 4'b1100; cmd_cnt = 3'd2; ser_in = 1'b1;
    bad = 0; done_at = 0; ready_at = 0; first_s = 2'bxx;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (i == 1) first_s = usr_s;
      if (cmd_ready !== ~busy) bad++;
      if (done === 1'b1 && done_at == 0) done_at = i;
      if (cmd_ready === 1'b1) begin
        ready_at = i;
        break;
      end
    end
    check("b2b_first_mode", 32'(first_s), 32'd0);
    check("b2b_ready_vs_busy", 32'(bad), 32'd0);
    check("b2b_done_at", 32'(done_at), 32'd2);
    check("b2b_ready_at", 32'(ready_at), 32'd3);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    done_at = 0; bad = 0;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      if (i < 3 && usr_s !== 2'b11) bad++;
      if (done === 1'b1 && done_at == 0) done_at = i;
    end
    check("b2b2_mode", 32'(bad), 32'd0);
    check("b2b2_done_at", 32'(done_at), 32'd3);
    @(negedge clk);
    check("b2b2_result", 32'(result), 32'b1111);

    // Reset during the third shift cycle of a long shift
    wait_idle();
    @(negedge clk);
    cmd_op = 2'b01; cmd_cnt = 3'd7; ser_in = 1'b0; cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_shift_mode", 32'(usr_s), 32'd2);
    rst = 1'b0;
    #1;
    check("abort_usr_s", 32'(usr_s), 32'd1);
    check("abort_flags", {29'd0, busy, done, usr_rdin}, 32'd0);
    check("abort_result", 32'(result), 32'd0);
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) bad++;
    end
    check("abort_no_done", 32'(bad), 32'd0);
    rst = 1'b1;
    cmd_op = 2'b00; cmd_data = 4'b0101; cmd_cnt = 3'd0; cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    @(negedge clk);
    check("post_rst_load", {26'd0, usr_s, usr_din}, {26'd0, 2'b00, 4'b0101});
    check("post_rst_busy", 32'(busy), 32'd1);
    @(negedge clk);
    check("post_rst_done", 32'(done), 32'd1);
    @(negedge clk);
    check("post_rst_result", 32'(result), 32'b0101);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
